// File: rtl/mode_pkg.sv
// Shared constants for the mode selector: debounce lengths for hardware and
// simulation, the mode indices used by the display muxes, and the step helper.
package mode_pkg;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
   localparam int DEBOUNCE_CYCLES_SIM     = 4;

   localparam int MODE_CLOCK = 0;
   localparam int MODE_TIMER = 1;
   localparam int MODE_ALARM = 2;
   localparam int MODE_SETUP = 3;

   // One step up or down, modulo num_modes, holding at the ends when not wrapping.
   function automatic int step_mode(input int cur, input bit up, input int num_modes, input bit wrap);
      if (up) begin
         if (cur == num_modes - 1) return wrap ? 0 : cur;
         return cur + 1;
      end
      if (cur == 0) return wrap ? num_modes - 1 : 0;
      return cur - 1;
   endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// Button, load and mode-output bundle between the board-facing logic and the
// mode sequencer.
interface mode_sequencer_if #(parameter int MODE_W = 2);

   logic              inc_btn;
   logic              dec_btn;
   logic              load_en;
   logic [MODE_W-1:0] load_mode;
   logic [MODE_W-1:0] mode_select;
   logic              mode_changed;
   logic              at_limit;

   modport master (
      output inc_btn, dec_btn, load_en, load_mode,
      input  mode_select, mode_changed, at_limit
   );

   modport slave (
      input  inc_btn, dec_btn, load_en, load_mode,
      output mode_select, mode_changed, at_limit
   );

endinterface

// File: rtl/button_debounce.sv
// Synchronises a raw push-button, debounces it into a stable level and emits a
// single-cycle registered pulse on each accepted press.
module button_debounce
   import mode_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk_100Mhz,
   input  logic reset_in,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_rise
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             stable_q, stable_d;
   logic             prev_q, prev_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter only runs while the synced input disagrees with the accepted level.
   always_comb begin
      sync1_d  = btn_raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = '0;
      prev_d   = stable_q;
      rise_d   = stable_q & ~prev_q;
      if (sync2_q != stable_q) begin
         if (cnt_q + 1'b1 == CNT_W'(DEBOUNCE_CYCLES)) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_100Mhz) begin
      if (reset_in) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         prev_q   <= 1'b0;
         rise_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         prev_q   <= prev_d;
         rise_q   <= rise_d;
         cnt_q    <= cnt_d;
      end
   end

   assign btn_level = stable_q;
   assign btn_rise  = rise_q;

endmodule

// File: rtl/mode_sequencer.sv
// Mode index register stepped by debounced inc/dec buttons or loaded directly,
// with a change pulse and an end-of-range flag aligned to the index.
module mode_sequencer
   import mode_pkg::*;
#(
   parameter int NUM_MODES       = 4,
   parameter int WRAP            = 1,
   parameter int RESET_MODE      = MODE_CLOCK,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input logic          clk_100Mhz,
   input logic          reset_in,
   mode_sequencer_if.slave bus
);

   localparam int MODE_W = $clog2(NUM_MODES);

   logic [1:0]        levels_unused;
   logic              inc_rise;
   logic              dec_rise;
   logic [MODE_W-1:0] mode_q, mode_d;
   logic              changed_q, changed_d;
   logic              at_limit_q, at_limit_d;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
      .clk_100Mhz(clk_100Mhz),
      .reset_in  (reset_in),
      .btn_raw   (bus.inc_btn),
      .btn_level (levels_unused[0]),
      .btn_rise  (inc_rise)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
      .clk_100Mhz(clk_100Mhz),
      .reset_in  (reset_in),
      .btn_raw   (bus.dec_btn),
      .btn_level (levels_unused[1]),
      .btn_rise  (dec_rise)
   );

   // A load always wins and swallows any step arriving in the same cycle.
   always_comb begin
      mode_d = mode_q;
      if (bus.load_en) begin
         if (int'(bus.load_mode) < NUM_MODES) mode_d = bus.load_mode;
      end else if (inc_rise && !dec_rise) begin
         mode_d = MODE_W'(step_mode(int'(mode_q), 1'b1, NUM_MODES, WRAP != 0));
      end else if (dec_rise && !inc_rise) begin
         mode_d = MODE_W'(step_mode(int'(mode_q), 1'b0, NUM_MODES, WRAP != 0));
      end
      changed_d  = (mode_d != mode_q);
      at_limit_d = (mode_d == '0) || (int'(mode_d) == NUM_MODES - 1);
   end

   always_ff @(posedge clk_100Mhz) begin
      if (reset_in) begin
         mode_q     <= MODE_W'(RESET_MODE);
         changed_q  <= 1'b0;
         at_limit_q <= (RESET_MODE == 0) || (RESET_MODE == NUM_MODES - 1);
      end else begin
         mode_q     <= mode_d;
         changed_q  <= changed_d;
         at_limit_q <= at_limit_d;
      end
   end

   assign bus.mode_select  = mode_q;
   assign bus.mode_changed = changed_q;
   assign bus.at_limit     = at_limit_q;

endmodule
